pic_rw_logic: RTL and testbench

- Bus-interface stage of the PIC, directly upstream of the control logic.
- Captures CPU writes (CS_n, WR_n, A0, D) and classifies each as ICW1–ICW4 or OCW1–OCW3 using the 8259A initialization sequence.
- Presents the command code, data byte and a commit strobe to the control logic.
- Decodes reads into IRR/ISR-read and IMR-read flags.

---
 rtl/pic_pkg.sv | 31 +++
 rtl/pic_cmd_decode.sv | 68 ++++++
 rtl/pic_rw_logic.sv | 127 ++++++++++++
 tb/tb_pic_rw_logic.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style PIC bus interface and control logic.
package pic_pkg;

   localparam int DATA_W = 8;

   // Command codes presented to the control logic
   localparam logic [2:0] CODE_ICW1 = 3'b000;
   localparam logic [2:0] CODE_ICW2 = 3'b001;
   localparam logic [2:0] CODE_ICW3 = 3'b010;
   localparam logic [2:0] CODE_ICW4 = 3'b011;
   localparam logic [2:0] CODE_OCW1 = 3'b100;
   localparam logic [2:0] CODE_OCW2 = 3'b101;
   localparam logic [2:0] CODE_OCW3 = 3'b110;
   localparam logic [2:0] IDLE_CODE = 3'b111;

   // Bit positions inside the written data byte
   localparam int IC4_BIT       = 0;
   localparam int SNGL_BIT      = 1;
   localparam int OCW3_MARK_BIT = 3;
   localparam int ICW1_MARK_BIT = 4;

   // Initialization sequence states
   typedef enum logic [2:0] {
      READY,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      OPER
   } pic_state_e;

endpackage

// File: rtl/pic_cmd_decode.sv
// Classifies a captured write into a command code and the following
// initialization state, given the current state and the ICW1 options.
module pic_cmd_decode
   import pic_pkg::*;
(
   input  pic_state_e                              state,
   input  logic                                    a0,
   input  logic [ICW1_MARK_BIT:OCW3_MARK_BIT]      d_mark,
   input  logic                                    sngl,
   input  logic                                    no_icw4,
   output logic                                    valid,
   output logic [2:0]                              code,
   output pic_state_e                              next_state
);

   // ICW1 wins in every state; otherwise the expected word depends on the state
   always_comb begin
      valid      = 1'b0;
      code       = IDLE_CODE;
      next_state = state;
      if (!a0 && d_mark[ICW1_MARK_BIT]) begin
         valid      = 1'b1;
         code       = CODE_ICW1;
         next_state = WAIT_ICW2;
      end else begin
         case (state)
            WAIT_ICW2: begin
               if (a0) begin
                  valid = 1'b1;
                  code  = CODE_ICW2;
                  if (!sngl)
                     next_state = WAIT_ICW3;
                  else if (!no_icw4)
                     next_state = WAIT_ICW4;
                  else
                     next_state = OPER;
               end
            end
            WAIT_ICW3: begin
               if (a0) begin
                  valid      = 1'b1;
                  code       = CODE_ICW3;
                  next_state = no_icw4 ? OPER : WAIT_ICW4;
               end
            end
            WAIT_ICW4: begin
               if (a0) begin
                  valid      = 1'b1;
                  code       = CODE_ICW4;
                  next_state = OPER;
               end
            end
            OPER: begin
               valid = 1'b1;
               if (a0)
                  code = CODE_OCW1;
               else if (!d_mark[OCW3_MARK_BIT])
                  code = CODE_OCW2;
               else
                  code = CODE_OCW3;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/pic_rw_logic.sv
// PIC bus-interface stage: captures CPU writes, commits them as ICW/OCW
// commands on WR_n release, and registers read-select flags.
module pic_rw_logic
   import pic_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              CS_n,
   input  logic              WR_n,
   input  logic              RD_n,
   input  logic              A0,
   input  logic [DATA_W-1:0] D_in,
   output logic [2:0]        WR_cur,
   output logic [DATA_W-1:0] Ds,
   output logic              wr_strobe,
   output logic              NO_ICW4,
   output logic              SNGL,
   output logic              init_done,
   output logic              RD_flag,
   output logic              rd_imr
);

   pic_state_e        state_q, state_d;
   logic              wr_active_q, wr_active_d;
   logic              wr_seen_high_q, wr_seen_high_d;
   logic              hold_a0_q, hold_a0_d;
   logic [DATA_W-1:0] hold_d_q, hold_d_d;
   logic [2:0]        wr_cur_q, wr_cur_d;
   logic [DATA_W-1:0] ds_q, ds_d;
   logic              wr_strobe_q, wr_strobe_d;
   logic              no_icw4_q, no_icw4_d;
   logic              sngl_q, sngl_d;
   logic              rd_flag_q, rd_flag_d;
   logic              rd_imr_q, rd_imr_d;

   logic              dec_valid;
   logic [2:0]        dec_code;
   pic_state_e        dec_next;

   pic_cmd_decode u_decode (
      .state      (state_q),
      .a0         (hold_a0_q),
      .d_mark     (hold_d_q[ICW1_MARK_BIT:OCW3_MARK_BIT]),
      .sngl       (sngl_q),
      .no_icw4    (no_icw4_q),
      .valid      (dec_valid),
      .code       (dec_code),
      .next_state (dec_next)
   );

   // Capture/abort/commit control; a write phase only counts if WR_n was
   // seen high since reset, so a strobe held across reset is discarded
   always_comb begin
      state_d        = state_q;
      wr_active_d    = wr_active_q;
      wr_seen_high_d = wr_seen_high_q | WR_n;
      hold_a0_d      = hold_a0_q;
      hold_d_d       = hold_d_q;
      wr_cur_d       = wr_cur_q;
      ds_d           = ds_q;
      wr_strobe_d    = 1'b0;
      no_icw4_d      = no_icw4_q;
      sngl_d         = sngl_q;
      rd_flag_d      = !CS_n && !RD_n && WR_n && !A0;
      rd_imr_d       = !CS_n && !RD_n && WR_n && A0;
      if (!CS_n && !WR_n && RD_n && wr_seen_high_q) begin
         wr_active_d = 1'b1;
         hold_a0_d   = A0;
         hold_d_d    = D_in;
      end else if (wr_active_q && CS_n) begin
         wr_active_d = 1'b0;
      end else if (wr_active_q && WR_n) begin
         wr_active_d = 1'b0;
         if (dec_valid) begin
            wr_cur_d    = dec_code;
            ds_d        = hold_d_q;
            wr_strobe_d = 1'b1;
            state_d     = dec_next;
            if (dec_code == CODE_ICW1) begin
               sngl_d    = hold_d_q[SNGL_BIT];
               no_icw4_d = ~hold_d_q[IC4_BIT];
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= READY;
         wr_active_q    <= 1'b0;
         wr_seen_high_q <= 1'b0;
         hold_a0_q      <= 1'b0;
         hold_d_q       <= '0;
         wr_cur_q       <= IDLE_CODE;
         ds_q           <= '0;
         wr_strobe_q    <= 1'b0;
         no_icw4_q      <= 1'b0;
         sngl_q         <= 1'b0;
         rd_flag_q      <= 1'b0;
         rd_imr_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_active_q    <= wr_active_d;
         wr_seen_high_q <= wr_seen_high_d;
         hold_a0_q      <= hold_a0_d;
         hold_d_q       <= hold_d_d;
         wr_cur_q       <= wr_cur_d;
         ds_q           <= ds_d;
         wr_strobe_q    <= wr_strobe_d;
         no_icw4_q      <= no_icw4_d;
         sngl_q         <= sngl_d;
         rd_flag_q      <= rd_flag_d;
         rd_imr_q       <= rd_imr_d;
      end
   end

   assign WR_cur    = wr_cur_q;
   assign Ds        = ds_q;
   assign wr_strobe = wr_strobe_q;
   assign NO_ICW4   = no_icw4_q;
   assign SNGL      = sngl_q;
   assign init_done = (state_q == OPER);
   assign RD_flag   = rd_flag_q;
   assign rd_imr    = rd_imr_q;

endmodule

// File: tb/tb_pic_rw_logic.sv
// Self-checking bench for pic_rw_logic: directed init/operation scenarios
// plus a randomized write/read stream against a sequence-level model.
module tb_pic_rw_logic;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       CS_n = 1'b1;
   logic       WR_n = 1'b1;
   logic       RD_n = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] D_in = 8'h00;
   logic [2:0] WR_cur;
   logic [7:0] Ds;
   logic       wr_strobe, NO_ICW4, SNGL, init_done, RD_flag, rd_imr;

   int n_tests = 0;
   int n_fail = 0;
   int strobe_count = 0;

   // Model of the init sequence: m_phase is the next ICW number expected
   // (0 = not initialized, 2..4 = waiting for ICWn, 9 = operational)
   int         m_phase;
   logic       m_sngl, m_no_icw4;
   logic [2:0] m_code;
   logic [7:0] m_ds;

   pic_rw_logic dut (
      .clk       (clk),
      .reset     (reset),
      .CS_n      (CS_n),
      .WR_n      (WR_n),
      .RD_n      (RD_n),
      .A0        (A0),
      .D_in      (D_in),
      .WR_cur    (WR_cur),
      .Ds        (Ds),
      .wr_strobe (wr_strobe),
      .NO_ICW4   (NO_ICW4),
      .SNGL      (SNGL),
      .init_done (init_done),
      .RD_flag   (RD_flag),
      .rd_imr    (rd_imr)
   );

   always #5 clk = ~clk;

   // Counts every cycle in which the strobe is high
   always @(negedge clk) if (wr_strobe === 1'b1) strobe_count <= strobe_count + 1;

   task automatic model_reset();
      m_phase = 0; m_sngl = 1'b0; m_no_icw4 = 1'b0; m_code = 3'b111; m_ds = 8'h00;
   endtask

   task automatic model_write(input logic a0, input logic [7:0] d, output logic valid);
      valid = 1'b0;
      if (!a0 && d[4]) begin
         valid = 1'b1; m_code = 3'd0; m_sngl = d[1]; m_no_icw4 = ~d[0]; m_phase = 2;
      end else if (m_phase >= 2 && m_phase <= 4) begin
         if (a0) begin
            valid = 1'b1;
            m_code = 3'(m_phase - 1);
            if (m_phase == 2) m_phase = !m_sngl ? 3 : (!m_no_icw4 ? 4 : 9);
            else if (m_phase == 3) m_phase = !m_no_icw4 ? 4 : 9;
            else m_phase = 9;
         end
      end else if (m_phase == 9) begin
         valid = 1'b1;
         m_code = a0 ? 3'd4 : (d[3] ? 3'd6 : 3'd5);
      end
      if (valid) m_ds = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // One full write cycle; returns strobe/code/data at the commit edge and the strobe one cycle later
   task automatic do_write(input logic a0, input logic [7:0] d, output logic s1,
                           output logic [2:0] c, output logic [7:0] ds, output logic s2);
      @(negedge clk);
      CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b1; A0 = a0; D_in = d;
      @(negedge clk);
      WR_n = 1'b1; A0 = ~a0; D_in = ~d;
      @(posedge clk); #1;
      s1 = wr_strobe; c = WR_cur; ds = Ds;
      @(negedge clk);
      CS_n = 1'b1;
      @(posedge clk); #1;
      s2 = wr_strobe;
   endtask

   task automatic do_read(input logic a0, output logic [1:0] during, output logic [1:0] after);
      @(negedge clk);
      CS_n = 1'b0; RD_n = 1'b0; WR_n = 1'b1; A0 = a0;
      @(posedge clk); #1;
      during = {RD_flag, rd_imr};
      @(negedge clk);
      CS_n = 1'b1; RD_n = 1'b1;
      @(posedge clk); #1;
      after = {RD_flag, rd_imr};
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({WR_cur, Ds, wr_strobe, NO_ICW4, SNGL, init_done, RD_flag, rd_imr} !== {3'b111, 8'h00, 6'b0}) begin
         n_fail++;
         $display("[TB] FAIL reset_values: got %h/%h/%b%b%b%b%b%b expected 7/00/000000",
                  WR_cur, Ds, wr_strobe, NO_ICW4, SNGL, init_done, RD_flag, rd_imr);
      end
   endtask

   task automatic test_single_init();
      logic s1, s2; logic [2:0] c; logic [7:0] ds;
      do_reset();
      do_write(1'b0, 8'h13, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, s2} !== {1'b1, 3'b000, 8'h13, 1'b0}) begin
         n_fail++; $display("[TB] FAIL single_icw1: got s=%b c=%b d=%h s2=%b expected 1 000 13 0", s1, c, ds, s2);
      end
      do_write(1'b1, 8'hA8, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, s2, init_done} !== {1'b1, 3'b001, 8'hA8, 1'b0, 1'b0}) begin
         n_fail++; $display("[TB] FAIL single_icw2: got s=%b c=%b d=%h s2=%b id=%b expected 1 001 a8 0 0", s1, c, ds, s2, init_done);
      end
      do_write(1'b1, 8'h03, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, s2} !== {1'b1, 3'b011, 8'h03, 1'b0}) begin
         n_fail++; $display("[TB] FAIL single_icw4: got s=%b c=%b d=%h s2=%b expected 1 011 03 0", s1, c, ds, s2);
      end
      n_tests++;
      if ({SNGL, NO_ICW4, init_done} !== 3'b101) begin
         n_fail++; $display("[TB] FAIL single_flags: got SNGL/NO_ICW4/init_done=%b%b%b expected 101", SNGL, NO_ICW4, init_done);
      end
   endtask

   task automatic test_cascade_init();
      logic s1, s2; logic [2:0] c; logic [7:0] ds;
      do_reset();
      do_write(1'b0, 8'h11, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, s2} !== {1'b1, 3'b000, 1'b0}) begin
         n_fail++; $display("[TB] FAIL cascade_icw1: got s=%b c=%b s2=%b expected 1 000 0", s1, c, s2);
      end
      do_write(1'b1, 8'h20, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, s2} !== {1'b1, 3'b001, 1'b0}) begin
         n_fail++; $display("[TB] FAIL cascade_icw2: got s=%b c=%b s2=%b expected 1 001 0", s1, c, s2);
      end
      do_write(1'b1, 8'h04, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, s2} !== {1'b1, 3'b010, 8'h04, 1'b0}) begin
         n_fail++; $display("[TB] FAIL cascade_icw3: got s=%b c=%b d=%h s2=%b expected 1 010 04 0", s1, c, ds, s2);
      end
      do_write(1'b1, 8'h01, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, s2, SNGL, NO_ICW4, init_done} !== {1'b1, 3'b011, 1'b0, 3'b001}) begin
         n_fail++; $display("[TB] FAIL cascade_icw4: got s=%b c=%b s2=%b flags=%b%b%b expected 1 011 0 001", s1, c, s2, SNGL, NO_ICW4, init_done);
      end
   endtask

   task automatic test_oper_commands();
      logic s1, s2; logic [2:0] c; logic [7:0] ds;
      int c0;
      do_write(1'b1, 8'h02, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b1, 3'b100, 8'h02}) begin
         n_fail++; $display("[TB] FAIL ocw1: got s=%b c=%b d=%h expected 1 100 02", s1, c, ds);
      end
      do_write(1'b0, 8'h20, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b1, 3'b101, 8'h20}) begin
         n_fail++; $display("[TB] FAIL ocw2: got s=%b c=%b d=%h expected 1 101 20", s1, c, ds);
      end
      do_write(1'b0, 8'h0B, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b1, 3'b110, 8'h0B}) begin
         n_fail++; $display("[TB] FAIL ocw3: got s=%b c=%b d=%h expected 1 110 0b", s1, c, ds);
      end
      c0 = strobe_count;
      do_write(1'b1, 8'hFF, s1, c, ds, s2);
      do_write(1'b1, 8'hFF, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, s2, init_done} !== {1'b1, 3'b100, 8'hFF, 1'b0, 1'b1} || strobe_count - c0 != 2) begin
         n_fail++; $display("[TB] FAIL ocw1_repeat: got s=%b c=%b d=%h id=%b strobes=%0d expected 1 100 ff 1 strobes=2",
                            s1, c, ds, init_done, strobe_count - c0);
      end
   endtask

   task automatic test_ignored_and_restart();
      logic s1, s2; logic [2:0] c; logic [7:0] ds;
      do_reset();
      do_write(1'b1, 8'h55, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds, init_done} !== {1'b0, 3'b111, 8'h00, 1'b0}) begin
         n_fail++; $display("[TB] FAIL ready_ignore: got s=%b c=%b d=%h id=%b expected 0 111 00 0", s1, c, ds, init_done);
      end
      do_write(1'b0, 8'h11, s1, c, ds, s2);
      do_write(1'b1, 8'h20, s1, c, ds, s2);
      do_write(1'b0, 8'h08, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b0, 3'b001, 8'h20}) begin
         n_fail++; $display("[TB] FAIL wait_ignore: got s=%b c=%b d=%h expected 0 001 20", s1, c, ds);
      end
      do_write(1'b0, 8'h13, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b1, 3'b000, 8'h13}) begin
         n_fail++; $display("[TB] FAIL restart_icw1: got s=%b c=%b d=%h expected 1 000 13", s1, c, ds);
      end
      do_write(1'b1, 8'h40, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, ds} !== {1'b1, 3'b001, 8'h40}) begin
         n_fail++; $display("[TB] FAIL restart_icw2: got s=%b c=%b d=%h expected 1 001 40", s1, c, ds);
      end
      do_write(1'b1, 8'h01, s1, c, ds, s2);
      n_tests++;
      if ({s1, c, init_done} !== {1'b1, 3'b011, 1'b1}) begin
         n_fail++; $display("[TB] FAIL restart_icw4: got s=%b c=%b id=%b expected 1 011 1", s1, c, init_done);
      end
   endtask

   task automatic test_abort();
      int c0 = strobe_count;
      @(negedge clk); CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b1; A0 = 1'b1; D_in = 8'h77;
      @(negedge clk); CS_n = 1'b1;
      @(negedge clk); WR_n = 1'b1;
      @(negedge clk); CS_n = 1'b0;
      repeat (2) @(negedge clk);
      CS_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (strobe_count != c0 || WR_cur !== 3'b011 || Ds !== 8'h01) begin
         n_fail++; $display("[TB] FAIL abort: got strobes=%0d c=%b d=%h expected strobes=0 011 01", strobe_count - c0, WR_cur, Ds);
      end
   endtask

   task automatic test_reset_mid_write();
      logic s1, s2; logic [2:0] c; logic [7:0] ds;
      int c0;
      @(negedge clk); CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b1; A0 = 1'b1; D_in = 8'h3C;
      @(posedge clk); #2 reset = 1'b1;
      c0 = strobe_count;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); WR_n = 1'b1;
      repeat (2) @(negedge clk);
      CS_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (strobe_count != c0 ||
          {WR_cur, Ds, wr_strobe, NO_ICW4, SNGL, init_done, RD_flag, rd_imr} !== {3'b111, 8'h00, 6'b0}) begin
         n_fail++; $display("[TB] FAIL reset_mid_write: got strobes=%0d c=%b d=%h flags=%b%b%b%b expected 0 111 00 0000",
                            strobe_count - c0, WR_cur, Ds, NO_ICW4, SNGL, init_done, wr_strobe);
      end
      do_write(1'b1, 8'h55, s1, c, ds, s2);
      n_tests++;
      if ({s1, c} !== {1'b0, 3'b111}) begin
         n_fail++; $display("[TB] FAIL post_reset_ready: got s=%b c=%b expected 0 111", s1, c);
      end
   endtask

   task automatic test_bus_conflict();
      logic [1:0] f1, f2;
      int c0 = strobe_count;
      @(negedge clk); CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b0; A0 = 1'b0; D_in = 8'h13;
      @(posedge clk); #1 f1 = {RD_flag, rd_imr};
      @(negedge clk); A0 = 1'b1;
      @(posedge clk); #1 f2 = {RD_flag, rd_imr};
      @(negedge clk); WR_n = 1'b1; RD_n = 1'b1;
      repeat (2) @(negedge clk);
      CS_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (f1 !== 2'b00 || f2 !== 2'b00 || strobe_count != c0 || WR_cur !== 3'b111) begin
         n_fail++; $display("[TB] FAIL bus_conflict: got flags=%b/%b strobes=%0d c=%b expected 00/00 0 111",
                            f1, f2, strobe_count - c0, WR_cur);
      end
   endtask

   task automatic test_reads();
      logic [1:0] dur, aft;
      do_read(1'b0, dur, aft);
      n_tests++;
      if ({dur, aft} !== 4'b1000) begin
         n_fail++; $display("[TB] FAIL read_irr: got flags=%b then %b expected 10 then 00", dur, aft);
      end
      do_read(1'b1, dur, aft);
      n_tests++;
      if ({dur, aft} !== 4'b0100) begin
         n_fail++; $display("[TB] FAIL read_imr: got flags=%b then %b expected 01 then 00", dur, aft);
      end
   endtask

   task automatic test_random();
      logic s1, s2, v, a0; logic [2:0] c; logic [7:0] ds, d; logic [1:0] dur, aft;
      do_reset();
      model_reset();
      for (int i = 0; i < 300; i++) begin
         a0 = 1'($urandom_range(0, 1));
         d  = 8'($urandom);
         model_write(a0, d, v);
         do_write(a0, d, s1, c, ds, s2);
         n_tests++;
         if ({s1, c, ds, s2} !== {v, m_code, m_ds, 1'b0}) begin
            n_fail++; $display("[TB] FAIL random_write[%0d] a0=%b d=%h: got s=%b c=%b d=%h s2=%b expected %b %b %h 0",
                               i, a0, d, s1, c, ds, s2, v, m_code, m_ds);
         end
         n_tests++;
         if ({init_done, SNGL, NO_ICW4} !== {(m_phase == 9), m_sngl, m_no_icw4}) begin
            n_fail++; $display("[TB] FAIL random_flags[%0d]: got id/SNGL/NO_ICW4=%b%b%b expected %b%b%b",
                               i, init_done, SNGL, NO_ICW4, (m_phase == 9), m_sngl, m_no_icw4);
         end
         if ($urandom_range(0, 2) == 0) begin
            a0 = 1'($urandom_range(0, 1));
            do_read(a0, dur, aft);
            n_tests++;
            if ({dur, aft, WR_cur, init_done} !== {~a0, a0, 2'b00, m_code, (m_phase == 9)}) begin
               n_fail++; $display("[TB] FAIL random_read[%0d] a0=%b: got flags=%b/%b c=%b id=%b expected %b%b/00 %b %b",
                                  i, a0, dur, aft, WR_cur, init_done, ~a0, a0, m_code, (m_phase == 9));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_init();
      test_cascade_init();
      test_oper_commands();
      test_ignored_and_restart();
      test_abort();
      test_reset_mid_write();
      test_bus_conflict();
      test_reads();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
